// File: rtl/noc_vc_merge_pkg.sv
// Shared NoC definitions for the VC merge block.
// Flit width, VC count, arbiter states and the buffered entry layout.
package noc_vc_merge_pkg;

    localparam int Noc_Data_Width = 32;
    localparam int Noc_VC_Channel = 2;

    typedef enum logic [1:0] {
        NOC_MERGE_IDLE  = 2'd0,
        NOC_MERGE_LOCK0 = 2'd1,
        NOC_MERGE_LOCK1 = 2'd2
    } merge_state_t;

    typedef struct packed {
        logic                      is_tail;
        logic                      is_header;
        logic [Noc_Data_Width-1:0] flit;
    } flit_entry_t;

endpackage

// File: rtl/noc_vc_merge_fifo.sv
// Per-channel flit FIFO with wrap-around pointers.
// The extra pointer MSB separates full from empty; push refused when full.
module noc_vc_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Advance pointers on accepted push/pop; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/noc_vc_merge.sv
// Merges two VC channel flit streams into one ejection stream.
// Packet-level wormhole arbitration, round-robin at header boundaries.
module noc_vc_merge
    import noc_vc_merge_pkg::*;
#(
    parameter int FIFO_DEPTH      = 4,
    parameter int VC_READY_THRESH = 4
) (
    input  logic                      noc_clk,
    input  logic                      noc_rst,
    input  logic                      Noc_channel0_receive_valid,
    output logic                      Noc_channel0_receive_ready,
    input  logic [Noc_Data_Width-1:0] Noc_channel0_receive_flit,
    input  logic                      Noc_channel0_receive_is_header,
    input  logic                      Noc_channel0_receive_is_tail,
    output logic                      Noc_channel0_receive_VCready,
    input  logic                      Noc_channel1_receive_valid,
    output logic                      Noc_channel1_receive_ready,
    input  logic [Noc_Data_Width-1:0] Noc_channel1_receive_flit,
    input  logic                      Noc_channel1_receive_is_header,
    input  logic                      Noc_channel1_receive_is_tail,
    output logic                      Noc_channel1_receive_VCready,
    output logic                      Noc_sender_valid,
    input  logic                      Noc_sender_ready,
    output logic [Noc_Data_Width-1:0] Noc_sender_flit,
    output logic                      Noc_sender_is_header,
    output logic                      Noc_sender_is_tail,
    output logic                      Noc_merge_err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = $bits(flit_entry_t);

    merge_state_t state;
    logic         rr;
    logic         first;
    logic         err;

    flit_entry_t  wr0, wr1, head0, head1, out_e;
    logic         full0, full1, empty0, empty1;
    logic [CW-1:0] count0, count1;
    logic         pop0, pop1;
    logic         cand0, cand1, bad0, bad1;
    logic         grant0, grant1;
    logic         sel_valid;

    assign wr0 = {Noc_channel0_receive_is_tail,
                  Noc_channel0_receive_is_header,
                  Noc_channel0_receive_flit};
    assign wr1 = {Noc_channel1_receive_is_tail,
                  Noc_channel1_receive_is_header,
                  Noc_channel1_receive_flit};

    noc_vc_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk   (noc_clk),
        .rst   (noc_rst),
        .push  (Noc_channel0_receive_valid),
        .pop   (pop0),
        .wdata (wr0),
        .rdata (head0),
        .full  (full0),
        .empty (empty0),
        .count (count0)
    );

    noc_vc_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk   (noc_clk),
        .rst   (noc_rst),
        .push  (Noc_channel1_receive_valid),
        .pop   (pop1),
        .wdata (wr1),
        .rdata (head1),
        .full  (full1),
        .empty (empty1),
        .count (count1)
    );

    assign cand0 = !empty0 && head0.is_header;
    assign cand1 = !empty1 && head1.is_header;
    assign bad0  = !empty0 && !head0.is_header;
    assign bad1  = !empty1 && !head1.is_header;

    // Grant, discard and output-select decisions for the current state.
    always_comb begin
        pop0      = 1'b0;
        pop1      = 1'b0;
        grant0    = 1'b0;
        grant1    = 1'b0;
        sel_valid = 1'b0;
        out_e     = '0;
        unique case (state)
            NOC_MERGE_IDLE: begin
                pop0 = bad0;
                pop1 = bad1;
                if (cand0 && (!cand1 || !rr)) grant0 = 1'b1;
                else if (cand1)               grant1 = 1'b1;
            end
            NOC_MERGE_LOCK0: begin
                sel_valid = !empty0;
                if (!empty0) out_e = head0;
                pop0 = sel_valid && Noc_sender_ready;
            end
            NOC_MERGE_LOCK1: begin
                sel_valid = !empty1;
                if (!empty1) out_e = head1;
                pop1 = sel_valid && Noc_sender_ready;
            end
            default: ;
        endcase
    end

    // Arbiter FSM: lock on grant, release on popped tail, sticky error.
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            state <= NOC_MERGE_IDLE;
            rr    <= 1'b0;
            first <= 1'b0;
            err   <= 1'b0;
        end else begin
            unique case (state)
                NOC_MERGE_IDLE: begin
                    if (bad0 || bad1) err <= 1'b1;
                    if (grant0) begin
                        state <= NOC_MERGE_LOCK0;
                        first <= 1'b1;
                    end else if (grant1) begin
                        state <= NOC_MERGE_LOCK1;
                        first <= 1'b1;
                    end
                end
                NOC_MERGE_LOCK0: begin
                    if (pop0) begin
                        first <= 1'b0;
                        if (head0.is_header && !first) err <= 1'b1;
                        if (head0.is_tail) begin
                            state <= NOC_MERGE_IDLE;
                            rr    <= 1'b1;
                        end
                    end
                end
                NOC_MERGE_LOCK1: begin
                    if (pop1) begin
                        first <= 1'b0;
                        if (head1.is_header && !first) err <= 1'b1;
                        if (head1.is_tail) begin
                            state <= NOC_MERGE_IDLE;
                            rr    <= 1'b0;
                        end
                    end
                end
                default: state <= NOC_MERGE_IDLE;
            endcase
        end
    end

    assign Noc_channel0_receive_ready   = !full0 || noc_rst;
    assign Noc_channel1_receive_ready   = !full1 || noc_rst;
    assign Noc_channel0_receive_VCready = noc_rst ||
        ((FIFO_DEPTH - int'(count0)) >= VC_READY_THRESH);
    assign Noc_channel1_receive_VCready = noc_rst ||
        ((FIFO_DEPTH - int'(count1)) >= VC_READY_THRESH);

    assign Noc_sender_valid     = sel_valid && !noc_rst;
    assign Noc_sender_flit      = noc_rst ? '0 : out_e.flit;
    assign Noc_sender_is_header = out_e.is_header && !noc_rst;
    assign Noc_sender_is_tail   = out_e.is_tail && !noc_rst;
    assign Noc_merge_err        = err && !noc_rst;

endmodule

// File: tb/tb_noc_vc_merge.sv
// Directed table-driven bench for noc_vc_merge.
// Each row: inputs for one cycle and the outputs expected in that cycle.
module tb_noc_vc_merge;

    logic        clk;
    logic        rst;
    logic        v0, h0, t0, v1, h1, t1;
    logic [31:0] f0, f1;
    logic        srdy;
    logic        r0, r1, vc0, vc1;
    logic        sv, sh, st, err;
    logic [31:0] sf;

    int n_chk;
    int n_fail;

    noc_vc_merge dut (
        .noc_clk                        (clk),
        .noc_rst                        (rst),
        .Noc_channel0_receive_valid     (v0),
        .Noc_channel0_receive_ready     (r0),
        .Noc_channel0_receive_flit      (f0),
        .Noc_channel0_receive_is_header (h0),
        .Noc_channel0_receive_is_tail   (t0),
        .Noc_channel0_receive_VCready   (vc0),
        .Noc_channel1_receive_valid     (v1),
        .Noc_channel1_receive_ready     (r1),
        .Noc_channel1_receive_flit      (f1),
        .Noc_channel1_receive_is_header (h1),
        .Noc_channel1_receive_is_tail   (t1),
        .Noc_channel1_receive_VCready   (vc1),
        .Noc_sender_valid               (sv),
        .Noc_sender_ready               (srdy),
        .Noc_sender_flit                (sf),
        .Noc_sender_is_header           (sh),
        .Noc_sender_is_tail             (st),
        .Noc_merge_err                  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic [2:0]  c0;
        logic [31:0] f0;
        logic [2:0]  c1;
        logic [31:0] f1;
        logic        rdy;
        logic [2:0]  oc;
        logic [31:0] of;
        logic [4:0]  st;
    } vec_t;

    // input control {valid, header, tail}
    localparam logic [2:0] NO  = 3'b000;
    localparam logic [2:0] VD  = 3'b100;
    localparam logic [2:0] VH  = 3'b110;
    localparam logic [2:0] VT  = 3'b101;
    localparam logic [2:0] VHT = 3'b111;
    // output control {valid, header, tail}
    localparam logic [2:0] OI  = 3'b000;
    localparam logic [2:0] OH  = 3'b110;
    localparam logic [2:0] OD  = 3'b100;
    localparam logic [2:0] OT  = 3'b101;
    localparam logic [2:0] OHT = 3'b111;

    vec_t vq[$];

    function automatic vec_t mk(logic r, logic [2:0] c0_, logic [31:0] f0_,
                                logic [2:0] c1_, logic [31:0] f1_, logic rdy,
                                logic [2:0] oc, logic [31:0] of,
                                logic [4:0] stv);
        vec_t v;
        v.rst = r;  v.c0 = c0_; v.f0 = f0_; v.c1 = c1_; v.f1 = f1_;
        v.rdy = rdy; v.oc = oc; v.of = of; v.st = stv;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(vec_t v);
        rst  = v.rst;
        {v0, h0, t0} = v.c0; f0 = v.f0;
        {v1, h1, t1} = v.c1; f1 = v.f1;
        srdy = v.rdy;
    endtask

    logic [31:0] got_f [3];
    logic [2:0]  got_c [3];
    int          n_got;
    int          first_i;

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        {v0, h0, t0, v1, h1, t1} = '0;
        f0 = '0; f1 = '0; srdy = 1'b0;
        repeat (2) @(posedge clk);

        // status bits: {r0, vc0, r1, vc1, err}
        vq.push_back(mk(1, NO, 0, NO, 0, 1, OI, 0, 5'b11110));
        // single-channel packet; first output two edges after header push
        vq.push_back(mk(0, VH, 32'hA1, NO, 0, 1, OI, 0, 5'b11110));
        vq.push_back(mk(0, VD, 32'hA2, NO, 0, 1, OI, 0, 5'b10110));
        vq.push_back(mk(0, VT, 32'hA3, NO, 0, 1, OH, 32'hA1, 5'b10110));
        vq.push_back(mk(0, NO, 0, NO, 0, 1, OD, 32'hA2, 5'b10110));
        vq.push_back(mk(0, NO, 0, NO, 0, 1, OT, 32'hA3, 5'b10110));
        // simultaneous headers with rr at ch1: ch1 first
        vq.push_back(mk(0, VH, 32'hD1, VH, 32'hE1, 1, OI, 0, 5'b11110));
        vq.push_back(mk(0, VT, 32'hD2, VT, 32'hE2, 1, OI, 0, 5'b10100));
        vq.push_back(mk(0, NO, 0, NO, 0, 1, OH, 32'hE1, 5'b10100));
        vq.push_back(mk(0, NO, 0, NO, 0, 1, OT, 32'hE2, 5'b10100));
        vq.push_back(mk(0, NO, 0, NO, 0, 1, OI, 0, 5'b10110));
        vq.push_back(mk(0, NO, 0, NO, 0, 1, OH, 32'hD1, 5'b10110));
        vq.push_back(mk(0, NO, 0, NO, 0, 1, OT, 32'hD2, 5'b10110));
        vq.push_back(mk(0, NO, 0, NO, 0, 1, OI, 0, 5'b11110));
        // after reset: ch0 first
        vq.push_back(mk(1, NO, 0, NO, 0, 1, OI, 0, 5'b11110));
        vq.push_back(mk(0, VH, 32'hB1, VH, 32'hC1, 1, OI, 0, 5'b11110));
        vq.push_back(mk(0, VT, 32'hB2, VT, 32'hC2, 1, OI, 0, 5'b10100));
        vq.push_back(mk(0, NO, 0, NO, 0, 1, OH, 32'hB1, 5'b10100));
        vq.push_back(mk(0, NO, 0, NO, 0, 1, OT, 32'hB2, 5'b10100));
        vq.push_back(mk(0, NO, 0, NO, 0, 1, OI, 0, 5'b11100));
        vq.push_back(mk(0, NO, 0, NO, 0, 1, OH, 32'hC1, 5'b11100));
        vq.push_back(mk(0, NO, 0, NO, 0, 1, OT, 32'hC2, 5'b11100));
        vq.push_back(mk(0, NO, 0, NO, 0, 1, OI, 0, 5'b11110));
        // lock hold with ready toggling; ch1 single-flit packet waits
        vq.push_back(mk(0, VH, 32'hF1, NO, 0, 1, OI, 0, 5'b11110));
        vq.push_back(mk(0, VD, 32'hF2, NO, 0, 1, OI, 0, 5'b10110));
        vq.push_back(mk(0, VT, 32'hF3, VHT, 32'h61, 1, OH, 32'hF1, 5'b10110));
        vq.push_back(mk(0, NO, 0, NO, 0, 0, OD, 32'hF2, 5'b10100));
        vq.push_back(mk(0, NO, 0, NO, 0, 1, OD, 32'hF2, 5'b10100));
        vq.push_back(mk(0, NO, 0, NO, 0, 0, OT, 32'hF3, 5'b10100));
        vq.push_back(mk(0, NO, 0, NO, 0, 1, OT, 32'hF3, 5'b10100));
        vq.push_back(mk(0, NO, 0, NO, 0, 1, OI, 0, 5'b11100));
        vq.push_back(mk(0, NO, 0, NO, 0, 1, OHT, 32'h61, 5'b11100));
        vq.push_back(mk(0, NO, 0, NO, 0, 1, OI, 0, 5'b11110));
        // fill ch0 to full under backpressure; 5th flit held by source
        vq.push_back(mk(0, VH, 32'hC01, NO, 0, 0, OI, 0, 5'b11110));
        vq.push_back(mk(0, VD, 32'hC02, NO, 0, 0, OI, 0, 5'b10110));
        vq.push_back(mk(0, VD, 32'hC03, NO, 0, 0, OH, 32'hC01, 5'b10110));
        vq.push_back(mk(0, VD, 32'hC04, NO, 0, 0, OH, 32'hC01, 5'b10110));
        vq.push_back(mk(0, VT, 32'hC05, NO, 0, 0, OH, 32'hC01, 5'b00110));
        vq.push_back(mk(0, VT, 32'hC05, NO, 0, 1, OH, 32'hC01, 5'b00110));
        vq.push_back(mk(0, VT, 32'hC05, NO, 0, 1, OD, 32'hC02, 5'b10110));
        vq.push_back(mk(0, NO, 0, NO, 0, 1, OD, 32'hC03, 5'b10110));
        vq.push_back(mk(0, NO, 0, NO, 0, 1, OD, 32'hC04, 5'b10110));
        vq.push_back(mk(0, NO, 0, NO, 0, 1, OT, 32'hC05, 5'b10110));
        vq.push_back(mk(0, NO, 0, NO, 0, 1, OI, 0, 5'b11110));
        // headerless flit on ch1 in IDLE is dropped, error sticks
        vq.push_back(mk(0, NO, 0, VD, 32'h55, 1, OI, 0, 5'b11110));
        vq.push_back(mk(0, NO, 0, NO, 0, 1, OI, 0, 5'b11100));
        vq.push_back(mk(0, NO, 0, VH, 32'h71, 1, OI, 0, 5'b11111));
        vq.push_back(mk(0, NO, 0, VT, 32'h72, 1, OI, 0, 5'b11101));
        vq.push_back(mk(0, NO, 0, NO, 0, 1, OH, 32'h71, 5'b11101));
        vq.push_back(mk(0, NO, 0, NO, 0, 1, OT, 32'h72, 5'b11101));
        vq.push_back(mk(0, NO, 0, NO, 0, 1, OI, 0, 5'b11111));
        // reset mid-packet in LOCK0 with two flits buffered
        vq.push_back(mk(0, VH, 32'h91, NO, 0, 0, OI, 0, 5'b11111));
        vq.push_back(mk(0, VD, 32'h92, NO, 0, 0, OI, 0, 5'b10111));
        vq.push_back(mk(0, NO, 0, NO, 0, 0, OH, 32'h91, 5'b10111));
        vq.push_back(mk(1, NO, 0, NO, 0, 0, OI, 0, 5'b11110));
        vq.push_back(mk(0, NO, 0, NO, 0, 1, OI, 0, 5'b11110));
        vq.push_back(mk(0, NO, 0, NO, 0, 1, OI, 0, 5'b11110));

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i]);
            #1;
            chk($sformatf("row%0d_out", i),
                64'({sv, sh, st, sf}), 64'({vq[i].oc, vq[i].of}));
            chk($sformatf("row%0d_status", i),
                64'({r0, vc0, r1, vc1, err}), 64'(vq[i].st));
        end

        // repeated header inside a locked packet: forwarded, flags error
        n_got = 0;
        first_i = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rst = 1'b0; srdy = 1'b1; v1 = 1'b0; h1 = 1'b0; t1 = 1'b0;
            v0 = (i < 3);
            h0 = (i < 2);
            t0 = (i == 2);
            f0 = 32'h80 + 32'(i);
            #1;
            if (sv && n_got < 3) begin
                if (first_i < 0) first_i = i;
                got_f[n_got] = sf;
                got_c[n_got] = {sv, sh, st};
                n_got++;
            end
        end
        chk("hdr_err_count", 64'(n_got), 64'd3);
        chk("hdr_err_latency", 64'(first_i), 64'd2);
        if (n_got == 3) begin
            chk("hdr_err_f0", 64'({got_c[0], got_f[0]}), 64'({OH, 32'h80}));
            chk("hdr_err_f1", 64'({got_c[1], got_f[1]}), 64'({OH, 32'h81}));
            chk("hdr_err_f2", 64'({got_c[2], got_f[2]}), 64'({OT, 32'h82}));
        end
        chk("hdr_err_flag", 64'(err), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_vc_merge.md
Name: noc_vc_merge

Overview:
- Receive-side counterpart of the NoC bridge, which splits one flit stream onto two VC channels.
- This block merges the two VC channel streams (channel0, channel1) back onto one flit stream.
- Each channel is buffered in a small FIFO. Arbitration is packet-level wormhole: round-robin between channels at header boundaries, with the grant locked until the tail flit.
- Sits between a router output port pair and the local ejection interface.

Parameters:
- Noc_Data_Width, 32 (from Noc_parameters.v), flit width.
- FIFO_DEPTH, 4, entries per channel FIFO; power of two, ≥2.
- VC_READY_THRESH, 4, minimum free entries for VCready to assert; range 1..FIFO_DEPTH.

Ports:
- noc_clk  in  1  clock.
- noc_rst  in  1  reset; synchronous, active-high.
- Noc_channel0_receive_valid  in  1  ch0 flit valid.
- Noc_channel0_receive_ready  out  1  ch0 FIFO not full.
- Noc_channel0_receive_flit  in  Noc_Data_Width  ch0 flit.
- Noc_channel0_receive_is_header  in  1  ch0 header marker.
- Noc_channel0_receive_is_tail  in  1  ch0 tail marker.
- Noc_channel0_receive_VCready  out  1  ch0 free entries ≥ VC_READY_THRESH.
- Noc_channel1_receive_valid/ready/flit/is_header/is_tail/VCready: same as ch0, for ch1.
- Noc_sender_valid  out  1  merged flit valid.
- Noc_sender_ready  in  1  downstream accepts.
- Noc_sender_flit  out  Noc_Data_Width  merged flit.
- Noc_sender_is_header  out  1  header marker.
- Noc_sender_is_tail  out  1  tail marker.
- Noc_merge_err  out  1  sticky protocol error.

Behaviour:
- Reset, and all state while noc_rst=1:
  - FIFOs empty; state IDLE; rr pointer = ch0; Noc_merge_err=0.
  - Noc_sender_valid=0; flit/header/tail outputs 0.
  - receive_ready=1; VCready=1.
- Reset asserted mid-packet aborts the packet and discards all buffered flits. There is no partial-packet recovery.
- FIFO push: push when receive_valid & receive_ready. The stored entry is {is_tail, is_header, flit}.
- receive_ready = !full. There is no write-through on full: a push is refused when full even if a pop happens in the same cycle.
- Simultaneous push and pop on a non-full FIFO keeps the count unchanged.
- Count is tracked with wrap-around pointers plus an extra MSB to tell full from empty.
- VCready_k = (FIFO_DEPTH − count_k) ≥ VC_READY_THRESH, from registered count.
- A pushed entry is visible at the FIFO head on the next cycle.
- State machine, encoding IDLE=0, LOCK0=1, LOCK1=2:
  - IDLE, outputs: sender_valid=0.
  - IDLE, candidates: channel k is a candidate if its FIFO is non-empty and its head has is_header=1.
  - IDLE, grant: if both channels are candidates, grant the rr pointer channel; if one, grant it. Next state is LOCKk.
  - IDLE, bad head: a non-empty head with is_header=0 is popped and discarded, and Noc_merge_err is set.
  - IDLE, simultaneous cases: a discard and a grant can occur in the same cycle on different channels. A discarding channel is never granted that cycle.
  - LOCKk, outputs: sender_valid = !empty_k; flit, header and tail come from head_k (zero when empty_k).
  - LOCKk, pop: pop on sender_valid & sender_ready.
  - LOCKk, header error: a popped flit with is_header=1, other than the first flit of the lock, sets Noc_merge_err. It is forwarded unchanged.
  - LOCKk, tail: a popped flit with is_tail=1 returns the FSM to IDLE and sets rr pointer = other channel.
  - LOCKk, other channel: the non-locked channel keeps accepting into its FIFO; it is never popped.
  - Single-flit packet (is_header=1 and is_tail=1): the LOCK state lasts exactly one transfer cycle when sender_ready=1.
- Latency: a header pushed at edge t is at the head at t+1, IDLE grants at edge t+2, and the header appears on the output in cycle t+2.
- Throughput: one flit/cycle within a packet. There is one idle output cycle between packets.
- Backpressure: while sender_valid=1 & sender_ready=0, all sender outputs hold stable.
- Noc_merge_err clears only on reset.

Decomposition:
- Shared (Noc_parameters.v): Noc_Data_Width, Noc_VC_Channel (=2), and state encoding defines NOC_MERGE_IDLE / NOC_MERGE_LOCK0 / NOC_MERGE_LOCK1.
- Sub-module noc_vc_fifo, instantiated twice:
  - Parameters: WIDTH=Noc_Data_Width+2 and DEPTH.
  - Ports: push/pop, full/empty/count, head data.
- The arbiter FSM lives in noc_vc_merge.

Test Plan:
- Single-channel packet: ch0 pushes 3 flits (H=0xA1, 0xA2, T=0xA3), sender_ready=1 → output 0xA1/hdr, 0xA2, 0xA3/tail on consecutive cycles; first output 2 cycles after header push; FSM back to IDLE, rr→ch1.
- Simultaneous headers after reset: ch0 and ch1 each push 2-flit packets in the same cycle → ch0 packet fully first, one idle output cycle, then ch1 packet. A repeat puts ch1 first.
- Lock hold: ch1 header arrives while ch0 is mid-packet with sender_ready toggling 1,0,1 → no ch1 flit appears before the ch0 tail; outputs stable during ready=0.
- Full/VCready: FIFO_DEPTH=4, sender_ready=0, ch0 pushes 5 flits → ready drops after the 4th, the 5th is held by the source. VCready_0 drops after the 1st push (THRESH=4), and reasserts only when the FIFO drains to empty.
- Protocol error: ch1 pushes a non-header flit 0x55 while in IDLE → flit is discarded (never on the output), Noc_merge_err=1 and stays 1. A following valid ch1 packet forwards normally.
- Reset mid-packet: assert noc_rst while in LOCK0 with 2 flits buffered → next cycle sender_valid=0, FIFOs empty, err=0, VCready=1. Remaining flits are never emitted.
